// File: rtl/airlock_sequencer_if.sv
// Request/command bundle between the request generator, the sequencer and
// the door/pump drivers.
// Signalling: there is no valid/ready handshake on this bundle. The requests
// and pass_done are levels that are sampled on every rising clock edge. The
// commands are registered levels that stay valid for as long as they are high.
interface airlock_sequencer_if;
    logic arrive_req;
    logic depart_req;
    logic pass_done;
    logic outer_door_open;
    logic inner_door_open;
    logic pressurizing;
    logic depressurizing;
    logic pressurized;
    logic busy;
    logic seq_done;

    modport master (
        output arrive_req, depart_req, pass_done,
        input  outer_door_open, inner_door_open, pressurizing, depressurizing,
               pressurized, busy, seq_done
    );

    modport slave (
        input  arrive_req, depart_req, pass_done,
        output outer_door_open, inner_door_open, pressurizing, depressurizing,
               pressurized, busy, seq_done
    );
endinterface

// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: runs the arrive/depart door and pump sequence,
// times the pressure changes in seconds, and never opens both doors at once.
// state_o exposes the current FSM state for debug and checker binding.
module airlock_sequencer #(
    parameter int CLK_PER_SEC = 50_000_000,
    parameter int PRESS_SEC   = 7,
    parameter int DEPRESS_SEC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    airlock_sequencer_if.slave   bus,
    output logic [2:0]           state_o
);
    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic DIR_ARRIVE = 1'b0;
    localparam logic DIR_DEPART = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DEPRESS    = 3'd1,
        S_OUTER_OPEN = 3'd2,
        S_PRESS      = 3'd3,
        S_INNER_OPEN = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            dir_q, dir_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [9:0]      sec_q, sec_d;
    logic            armed_q, armed_d;
    logic            outer_q, outer_d;
    logic            inner_q, inner_d;
    logic            press_q, press_d;
    logic            depress_q, depress_d;
    logic            pz_q, pz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            presc_wrap;
    logic            timer_done;
    logic [9:0]      sec_last;
    logic            timed_state;
    logic            door_state;

    // Seconds target of the timed state currently occupied.
    assign sec_last    = (state_q == S_PRESS) ? 10'(PRESS_SEC - 1) : 10'(DEPRESS_SEC - 1);
    assign presc_wrap  = (presc_q == PW'(CLK_PER_SEC - 1));
    // Last cycle of a timed state: the seconds count reaches its target on this wrap.
    assign timer_done  = presc_wrap && (sec_q == sec_last);
    assign timed_state = (state_q == S_PRESS) || (state_q == S_DEPRESS);
    assign door_state  = (state_q == S_OUTER_OPEN) || (state_q == S_INNER_OPEN);

    // State register plus timer and door-arming registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_ARRIVE;
            presc_q <= '0;
            sec_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            armed_q <= armed_d;
        end
    end

    // Next-state logic: request arbitration, timed exits, door exits.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (bus.arrive_req) begin
                    dir_d   = DIR_ARRIVE;
                    state_d = pz_q ? S_DEPRESS : S_OUTER_OPEN;
                end else if (bus.depart_req) begin
                    dir_d   = DIR_DEPART;
                    state_d = pz_q ? S_INNER_OPEN : S_PRESS;
                end
            end
            S_DEPRESS:    if (timer_done) state_d = S_OUTER_OPEN;
            S_PRESS:      if (timer_done) state_d = S_INNER_OPEN;
            S_OUTER_OPEN: if (armed_q && bus.pass_done)
                              state_d = (dir_q == DIR_ARRIVE) ? S_PRESS : S_IDLE;
            S_INNER_OPEN: if (armed_q && bus.pass_done)
                              state_d = (dir_q == DIR_ARRIVE) ? S_IDLE : S_DEPRESS;
            default:      state_d = S_IDLE;
        endcase
    end

    // Timer and arming: counters restart whenever a timed state is entered or left,
    // and a door ignores pass_done on its entry cycle.
    always_comb begin
        presc_d = '0;
        sec_d   = '0;
        armed_d = door_state && (state_d == state_q);
        if (timed_state && (state_d == state_q)) begin
            if (presc_wrap) begin
                presc_d = '0;
                sec_d   = sec_q + 10'd1;
            end else begin
                presc_d = presc_q + PW'(1);
                sec_d   = sec_q;
            end
        end
    end

    // Output logic: commands follow the next state so they align with it once registered.
    always_comb begin
        outer_d   = (state_d == S_OUTER_OPEN);
        inner_d   = (state_d == S_INNER_OPEN);
        press_d   = (state_d == S_PRESS);
        depress_d = (state_d == S_DEPRESS);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_IDLE) &&
                    (((state_q == S_INNER_OPEN) && (dir_q == DIR_ARRIVE)) ||
                     ((state_q == S_OUTER_OPEN) && (dir_q == DIR_DEPART)));
        pz_d      = pz_q;
        if ((state_q == S_PRESS) && (state_d != S_PRESS))
            pz_d = 1'b1;
        if ((state_q == S_DEPRESS) && (state_d != S_DEPRESS))
            pz_d = 1'b0;
    end

    // Output registers; reset leaves the chamber reported at station pressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            outer_q   <= 1'b0;
            inner_q   <= 1'b0;
            press_q   <= 1'b0;
            depress_q <= 1'b0;
            pz_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            outer_q   <= outer_d;
            inner_q   <= inner_d;
            press_q   <= press_d;
            depress_q <= depress_d;
            pz_q      <= pz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.outer_door_open = outer_q;
    assign bus.inner_door_open = inner_q;
    assign bus.pressurizing    = press_q;
    assign bus.depressurizing  = depress_q;
    assign bus.pressurized     = pz_q;
    assign bus.busy            = busy_q;
    assign bus.seq_done        = done_q;
    assign state_o             = state_q;
endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed bench for airlock_sequencer with CLK_PER_SEC=4, PRESS_SEC=7,
// DEPRESS_SEC=8. Cycle n is the interval after the n-th rising edge; inputs
// are driven and outputs sampled 1 time unit after that edge.
// Output vector layout: {outer, inner, pressurizing, depressurizing, pressurized, busy, seq_done}.
module tb_airlock_sequencer;
    localparam int CPS = 4;
    localparam int PS  = 7;
    localparam int DS  = 8;

    localparam logic [6:0] O_IDLE_PZ   = 7'b0000100;
    localparam logic [6:0] O_IDLE_VAC  = 7'b0000000;
    localparam logic [6:0] O_DONE_PZ   = 7'b0000101;
    localparam logic [6:0] O_DONE_VAC  = 7'b0000001;
    localparam logic [6:0] O_DEPRESS   = 7'b0001110;
    localparam logic [6:0] O_PRESS     = 7'b0010010;
    localparam logic [6:0] O_OUTER     = 7'b1000010;
    localparam logic [6:0] O_INNER     = 7'b0100110;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] state_o;
    int         tests_run = 0;
    int         tests_failed = 0;

    airlock_sequencer_if bus();

    airlock_sequencer #(.CLK_PER_SEC(CPS), .PRESS_SEC(PS), .DEPRESS_SEC(DS)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .state_o (state_o)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {bus.outer_door_open, bus.inner_door_open, bus.pressurizing,
                bus.depressurizing, bus.pressurized, bus.busy, bus.seq_done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Safety invariants checked on every cycle out of reset.
    always @(negedge clk) begin
        if (rst) begin
            tests_run++;
            if ((bus.outer_door_open && bus.inner_door_open) ||
                (bus.pressurizing && bus.depressurizing) ||
                (bus.outer_door_open && bus.pressurized) ||
                (bus.inner_door_open && !bus.pressurized)) begin
                tests_failed++;
                $display("FAIL invariants at %0t: got %b", $time, outs());
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        bus.arrive_req = 1'b0;
        bus.depart_req = 1'b0;
        bus.pass_done  = 1'b0;
        ticks(2);
        tests_run++; if (outs() !== O_IDLE_PZ) begin tests_failed++; $display("FAIL reset_outputs: got %b exp %b", outs(), O_IDLE_PZ); end
        rst = 1'b1;
        ticks(2);
        tests_run++; if (outs() !== O_IDLE_PZ) begin tests_failed++; $display("FAIL idle_after_reset: got %b exp %b", outs(), O_IDLE_PZ); end
    endtask

    // Arrival from pressurized chamber: DEPRESS cycles 1..32, outer door from 33.
    task automatic test_arrive_depress();
        bus.arrive_req = 1'b1;                 // cycle 0
        tick(); bus.arrive_req = 1'b0;         // cycle 1
        tests_run++; if (outs() !== O_DEPRESS) begin tests_failed++; $display("FAIL depress_first: got %b exp %b", outs(), O_DEPRESS); end
        ticks(31);                             // cycle 32
        tests_run++; if (outs() !== O_DEPRESS) begin tests_failed++; $display("FAIL depress_last: got %b exp %b", outs(), O_DEPRESS); end
        tick();                                // cycle 33
        tests_run++; if (outs() !== O_OUTER) begin tests_failed++; $display("FAIL outer_open_33: got %b exp %b", outs(), O_OUTER); end
    endtask

    // Continue arrival: pass_done at 40, PRESS 41..68, inner 69..75, IDLE at 76.
    task automatic test_arrive_press();
        ticks(7); bus.pass_done = 1'b1;        // cycle 40
        tests_run++; if (outs() !== O_OUTER) begin tests_failed++; $display("FAIL outer_held_40: got %b exp %b", outs(), O_OUTER); end
        tick(); bus.pass_done = 1'b0;          // cycle 41
        tests_run++; if (outs() !== O_PRESS) begin tests_failed++; $display("FAIL press_first: got %b exp %b", outs(), O_PRESS); end
        ticks(27);                             // cycle 68
        tests_run++; if (outs() !== O_PRESS) begin tests_failed++; $display("FAIL press_last: got %b exp %b", outs(), O_PRESS); end
        tick();                                // cycle 69
        tests_run++; if (outs() !== O_INNER) begin tests_failed++; $display("FAIL inner_open_69: got %b exp %b", outs(), O_INNER); end
        ticks(6); bus.pass_done = 1'b1;        // cycle 75
        tick(); bus.pass_done = 1'b0;          // cycle 76
        tests_run++; if (outs() !== O_DONE_PZ) begin tests_failed++; $display("FAIL seq_done_76: got %b exp %b", outs(), O_DONE_PZ); end
        tick();                                // cycle 77
        tests_run++; if (outs() !== O_IDLE_PZ) begin tests_failed++; $display("FAIL seq_done_pulse: got %b exp %b", outs(), O_IDLE_PZ); end
    endtask

    // Departure from pressurized chamber; pass_done on a door's entry cycle is ignored.
    task automatic test_depart();
        bus.depart_req = 1'b1;                 // c0
        tick(); bus.depart_req = 1'b0;         // c1: inner entry
        bus.pass_done = 1'b1;
        tests_run++; if (outs() !== O_INNER) begin tests_failed++; $display("FAIL depart_inner: got %b exp %b", outs(), O_INNER); end
        tick(); bus.pass_done = 1'b0;          // c2
        tests_run++; if (outs() !== O_INNER) begin tests_failed++; $display("FAIL inner_entry_ignored: got %b exp %b", outs(), O_INNER); end
        tick(); bus.pass_done = 1'b1;          // c3
        tick(); bus.pass_done = 1'b0;          // c4
        tests_run++; if (outs() !== O_DEPRESS) begin tests_failed++; $display("FAIL depart_depress: got %b exp %b", outs(), O_DEPRESS); end
        ticks(31);                             // c35
        tests_run++; if (outs() !== O_DEPRESS) begin tests_failed++; $display("FAIL depart_depress_last: got %b exp %b", outs(), O_DEPRESS); end
        tick(); bus.pass_done = 1'b1;          // c36: outer entry
        tests_run++; if (outs() !== O_OUTER) begin tests_failed++; $display("FAIL depart_outer: got %b exp %b", outs(), O_OUTER); end
        tick();                                // c37
        tests_run++; if (outs() !== O_OUTER) begin tests_failed++; $display("FAIL outer_entry_ignored: got %b exp %b", outs(), O_OUTER); end
        tick(); bus.pass_done = 1'b0;          // c38
        tests_run++; if (outs() !== O_DONE_VAC) begin tests_failed++; $display("FAIL depart_done: got %b exp %b", outs(), O_DONE_VAC); end
        tick();                                // c39
        tests_run++; if (outs() !== O_IDLE_VAC) begin tests_failed++; $display("FAIL depart_idle: got %b exp %b", outs(), O_IDLE_VAC); end
    endtask

    // Arrival with the chamber already at vacuum skips DEPRESS.
    task automatic test_arrive_vacuum();
        bus.arrive_req = 1'b1;                 // c0
        tick(); bus.arrive_req = 1'b0;         // c1
        tests_run++; if (outs() !== O_OUTER) begin tests_failed++; $display("FAIL arrive_vac_outer: got %b exp %b", outs(), O_OUTER); end
        tick(); bus.pass_done = 1'b1;          // c2
        tick(); bus.pass_done = 1'b0;          // c3
        tests_run++; if (outs() !== O_PRESS) begin tests_failed++; $display("FAIL arrive_vac_press: got %b exp %b", outs(), O_PRESS); end
        ticks(28);                             // c31
        tests_run++; if (outs() !== O_INNER) begin tests_failed++; $display("FAIL arrive_vac_inner: got %b exp %b", outs(), O_INNER); end
        tick(); bus.pass_done = 1'b1;          // c32
        tick(); bus.pass_done = 1'b0;          // c33
        tests_run++; if (outs() !== O_DONE_PZ) begin tests_failed++; $display("FAIL arrive_vac_done: got %b exp %b", outs(), O_DONE_PZ); end
    endtask

    // Simultaneous requests: arrival first, held departure starts after seq_done.
    task automatic test_both_requests();
        bus.arrive_req = 1'b1;                 // c0
        bus.depart_req = 1'b1;
        tick(); bus.arrive_req = 1'b0;         // c1
        tests_run++; if (outs() !== O_DEPRESS) begin tests_failed++; $display("FAIL both_arrive_wins: got %b exp %b", outs(), O_DEPRESS); end
        ticks(32);                             // c33
        tests_run++; if (outs() !== O_OUTER) begin tests_failed++; $display("FAIL both_outer: got %b exp %b", outs(), O_OUTER); end
        tick(); bus.pass_done = 1'b1;          // c34
        tick(); bus.pass_done = 1'b0;          // c35
        tests_run++; if (outs() !== O_PRESS) begin tests_failed++; $display("FAIL both_press: got %b exp %b", outs(), O_PRESS); end
        ticks(28);                             // c63
        tests_run++; if (outs() !== O_INNER) begin tests_failed++; $display("FAIL both_inner: got %b exp %b", outs(), O_INNER); end
        tick(); bus.pass_done = 1'b1;          // c64
        tick(); bus.pass_done = 1'b0;          // c65
        tests_run++; if (outs() !== O_DONE_PZ) begin tests_failed++; $display("FAIL both_seq_done: got %b exp %b", outs(), O_DONE_PZ); end
        tick(); bus.depart_req = 1'b0;         // c66
        tests_run++; if (outs() !== O_INNER) begin tests_failed++; $display("FAIL both_depart_start: got %b exp %b", outs(), O_INNER); end
        tick(); bus.pass_done = 1'b1;          // c67
        tick(); bus.pass_done = 1'b0;          // c68
        ticks(32);                             // c100
        tests_run++; if (outs() !== O_OUTER) begin tests_failed++; $display("FAIL both_depart_outer: got %b exp %b", outs(), O_OUTER); end
        tick(); bus.pass_done = 1'b1;          // c101
        tick(); bus.pass_done = 1'b0;          // c102
        tests_run++; if (outs() !== O_DONE_VAC) begin tests_failed++; $display("FAIL both_depart_done: got %b exp %b", outs(), O_DONE_VAC); end
    endtask

    // Departure from vacuum goes through PRESS; reset inside PRESS aborts at once.
    task automatic test_reset_mid();
        bus.depart_req = 1'b1;                 // c0
        tick(); bus.depart_req = 1'b0;         // c1
        tests_run++; if (outs() !== O_PRESS) begin tests_failed++; $display("FAIL depart_vac_press: got %b exp %b", outs(), O_PRESS); end
        ticks(10);                             // c11
        rst = 1'b0;
        tick();                                // c12
        tests_run++; if (outs() !== O_IDLE_PZ) begin tests_failed++; $display("FAIL reset_mid_press: got %b exp %b", outs(), O_IDLE_PZ); end
        rst = 1'b1;
        ticks(3);
        tests_run++; if (outs() !== O_IDLE_PZ) begin tests_failed++; $display("FAIL idle_after_abort: got %b exp %b", outs(), O_IDLE_PZ); end
    endtask

    initial begin
        test_reset();
        test_arrive_depress();
        test_arrive_press();
        test_depart();
        test_arrive_vacuum();
        test_both_requests();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
